tick_sched: RTL and testbench

- Multi-channel event scheduler built on one shared prescaler.
- Divides clk down to a base tick, then runs NCH programmable countdown channels (periodic or one-shot) off that tick.
- Expiries are delivered one at a time on a valid/ready event port using round-robin arbitration.
- Sits between the clock domain and consumers such as LED blinkers, debouncers and UART timeouts, replacing per-consumer dividers.

---
 rtl/tick_sched.sv | 144 ++++++++++++++
 tb/tb_tick_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
// Shared-prescaler event scheduler: NCH countdown channels, round-robin valid/ready event port.
// Define TICK_SCHED_ONESHOT_EN to honour cfg_periodic; otherwise every channel auto-reloads.
module tick_sched #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int BASE_HZ = 1_000,
  parameter int NCH     = 4,
  parameter int CW      = 16,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic           cfg_en,
  input  logic           cfg_periodic,
  input  logic [CW-1:0]  cfg_period,
  output logic           evt_valid,
  output logic [CHW-1:0] evt_ch,
  input  logic           evt_ready,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] overrun,
  input  logic [NCH-1:0] ovr_clr
);

  localparam int DIV = CLK_HZ / BASE_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0]  presc;
  logic           base_tick;
  logic [CW-1:0]  cnt [NCH];
  logic [CW-1:0]  rld [NCH];
  logic [NCH-1:0] act, pend, ovr;
  logic [NCH-1:0] wr_oh, expire, gnt_oh, ovr_set;
  logic [CHW-1:0] ptr, gnt_ch;
  logic           gnt_v, load;

`ifdef TICK_SCHED_ONESHOT_EN
  logic [NCH-1:0] per;
`else
  logic unused_periodic;
  assign unused_periodic = cfg_periodic;
`endif

  assign base_tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= base_tick ? '0 : presc + PW'(1);
  end

  always_comb begin
    wr_oh = '0;
    if (cfg_we && (int'(cfg_ch) < NCH)) wr_oh[cfg_ch] = 1'b1;
  end

  always_comb begin
    expire = '0;
    for (int i = 0; i < NCH; i++)
      expire[i] = act[i] && base_tick && !wr_oh[i] && (cnt[i] == '0);
  end

  // Scan downward from ptr+NCH-1 so the last hit is the first pending at/after ptr.
  always_comb begin
    int idx;
    idx    = 0;
    gnt_v  = 1'b0;
    gnt_ch = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (pend[idx]) begin
        gnt_v  = 1'b1;
        gnt_ch = CHW'(idx);
      end
    end
  end

  assign load    = !evt_valid || evt_ready;
  assign gnt_oh  = (load && gnt_v) ? (NCH'(1) << gnt_ch) : '0;
  assign ovr_set = expire & pend & ~gnt_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= '0;
      pend <= '0;
      ovr  <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
      per  <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        rld[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_oh[i]) begin
          pend[i] <= 1'b0;
          if (cfg_en && (cfg_period != '0)) begin
            act[i] <= 1'b1;
            rld[i] <= cfg_period;
            cnt[i] <= cfg_period - CW'(1);
`ifdef TICK_SCHED_ONESHOT_EN
            per[i] <= cfg_periodic;
`endif
          end else begin
            act[i] <= 1'b0;
          end
        end else if (expire[i]) begin
          // A same-cycle grant consumes the old event; this sets it again for the new one.
          pend[i] <= 1'b1;
`ifdef TICK_SCHED_ONESHOT_EN
          if (per[i]) cnt[i] <= rld[i] - CW'(1);
          else        act[i] <= 1'b0;
`else
          cnt[i] <= rld[i] - CW'(1);
`endif
        end else begin
          if (gnt_oh[i]) pend[i] <= 1'b0;
          if (act[i] && base_tick) cnt[i] <= cnt[i] - CW'(1);
        end
        if (ovr_set[i])      ovr[i] <= 1'b1;
        else if (ovr_clr[i]) ovr[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      evt_valid <= gnt_v;
      if (gnt_v) begin
        evt_ch <= gnt_ch;
        ptr    <= (int'(gnt_ch) == NCH - 1) ? '0 : gnt_ch + CHW'(1);
      end
    end
  end

  assign active  = act;
  assign overrun = ovr;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched against an absolute-tick-target reference model.
`timescale 1ns/1ps
module tb_tick_sched;
  localparam int CLK_HZ = 1000, BASE_HZ = 100, DIV = 10, NCH = 4, CW = 8, CHW = 2;
  localparam int VW = 1 + CHW + 2 * NCH;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           cfg_we = 1'b0, cfg_en = 1'b0, cfg_periodic = 1'b0, evt_ready = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic [NCH-1:0] ovr_clr = '0;
  logic           evt_valid;
  logic [CHW-1:0] evt_ch;
  logic [NCH-1:0] active, overrun;

  int checks = 0, errors = 0;

  tick_sched #(.CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_periodic(cfg_periodic), .cfg_period(cfg_period), .evt_valid(evt_valid),
    .evt_ch(evt_ch), .evt_ready(evt_ready), .active(active), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  // Model: each running channel fires when the global base-tick count reaches its target.
  int cyc, ticks, m_ch, m_ptr;
  int target [NCH];
  int per_m  [NCH];
  bit m_act [NCH], m_per [NCH], m_pend [NCH], m_ovr [NCH];
  bit m_valid;

  function automatic void model_reset();
    cyc = 0; ticks = 0; m_ch = 0; m_ptr = 0; m_valid = 0;
    for (int i = 0; i < NCH; i++) begin
      target[i] = 0; per_m[i] = 0; m_act[i] = 0; m_per[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
  endfunction

  function automatic void model_update();
    bit bt, wr, ex;
    bit p_old [NCH];
    int g;
    bt = ((cyc % DIV) == DIV - 1);
    cyc++;
    if (bt) ticks++;
    p_old = m_pend;
    g = -1;
    if (!m_valid || evt_ready)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && p_old[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
    for (int i = 0; i < NCH; i++) begin
      wr = cfg_we && (int'(cfg_ch) == i);
      ex = m_act[i] && bt && !wr && (ticks == target[i]);
      if (g == i) m_pend[i] = 0;
      if (ex && p_old[i] && g != i) m_ovr[i] = 1;
      else if (ovr_clr[i]) m_ovr[i] = 0;
      if (ex) begin
        m_pend[i] = 1;
        if (m_per[i]) target[i] = target[i] + per_m[i];
        else m_act[i] = 0;
      end
      if (wr) begin
        m_pend[i] = 0;
        if (cfg_en && cfg_period != 0) begin
          m_act[i] = 1;
          per_m[i] = int'(cfg_period);
          target[i] = ticks + int'(cfg_period);
`ifdef TICK_SCHED_ONESHOT_EN
          m_per[i] = cfg_periodic;
`else
          m_per[i] = 1;
`endif
        end else begin
          m_act[i] = 0;
        end
      end
    end
    if (!m_valid || evt_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_ch = g;
        m_ptr = (g + 1) % NCH;
      end
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [NCH-1:0] a, o;
    for (int i = 0; i < NCH; i++) begin
      a[i] = m_act[i];
      o[i] = m_ovr[i];
    end
    return {m_valid, m_valid ? CHW'(m_ch) : CHW'(0), a, o};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; evt_ready = 1'b0; ovr_clr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_write(input int ch, input bit en, input bit periodic, input int period);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_en = en; cfg_periodic = periodic;
    cfg_period = CW'(period);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] obs;
    do_reset();
    evt_ready = 1'b0;
    do_write(0, 1, 1, 1);
    while (cyc < 21) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL reset_pre n=%0d got %h want %h", cyc, obs, model_vec());
      end
    end
    checks++;
    if ({evt_valid, evt_ch} !== 3'b100) begin
      errors++; $display("FAIL reset_held_evt got %b want 100", {evt_valid, evt_ch});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({evt_valid, evt_ch, active, overrun} !== '0) begin
      errors++; $display("FAIL reset_async got %h want 0", {evt_valid, evt_ch, active, overrun});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    do_write(0, 1, 1, 1);
    while (cyc < 11) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL reset_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      checks++;
      if (evt_valid !== (cyc == 11)) begin
        errors++; $display("FAIL first_tick n=%0d got %b want %b", cyc, evt_valid, cyc == 11);
      end
    end
  endtask

  task automatic test_periodic();
    logic [VW-1:0] obs;
    int pulses [$];
    do_reset();
    evt_ready = 1'b1;
    do_write(0, 1, 1, 3);
    while (cyc < 181) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL periodic_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      if (evt_valid) pulses.push_back(cyc);
    end
    checks++;
    if (pulses.size() != 6) begin
      errors++; $display("FAIL periodic_count got %0d want 6", pulses.size());
    end else begin
      checks++;
      if (pulses[0] != 31) begin
        errors++; $display("FAIL periodic_first got %0d want 31", pulses[0]);
      end
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (pulses[k] - pulses[k-1] != 30) begin
          errors++; $display("FAIL periodic_spacing k=%0d got %0d want 30", k, pulses[k] - pulses[k-1]);
        end
      end
    end
  endtask

  task automatic test_oneshot();
    logic [VW-1:0] obs;
    int npulse, first;
    npulse = 0; first = -1;
    do_reset();
    evt_ready = 1'b1;
    do_write(2, 1, 0, 2);
    while (cyc < 131) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL oneshot_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      if (evt_valid) begin
        npulse++;
        if (first < 0) first = cyc;
      end
`ifdef TICK_SCHED_ONESHOT_EN
      checks++;
      if (active[2] !== (cyc < 20)) begin
        errors++; $display("FAIL oneshot_active n=%0d got %b want %b", cyc, active[2], cyc < 20);
      end
`endif
    end
    checks++;
`ifdef TICK_SCHED_ONESHOT_EN
    if (npulse != 1 || first != 21) begin
      errors++; $display("FAIL oneshot_events got %0d@%0d want 1@21", npulse, first);
    end
`else
    if (npulse != 6 || first != 21 || active[2] !== 1'b1) begin
      errors++; $display("FAIL forced_periodic got %0d@%0d act %b want 6@21 act 1", npulse, first, active[2]);
    end
`endif
  endtask

  task automatic test_arbitration();
    logic [VW-1:0] obs;
    bit exp_v;
    do_reset();
    evt_ready = 1'b1;
    for (int c = 0; c < NCH; c++) do_write(c, 1, 1, 1);
    while (cyc < 26) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL arb_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      exp_v = (cyc >= 11 && cyc <= 14) || (cyc >= 21 && cyc <= 24);
      checks++;
      if (evt_valid !== exp_v || (exp_v && int'(evt_ch) != (cyc % 10) - 1)) begin
        errors++; $display("FAIL arb_order n=%0d got %b/%0d want %b/%0d", cyc, evt_valid, evt_ch, exp_v, (cyc % 10) - 1);
      end
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [VW-1:0] obs;
    bit exp_o;
    do_reset();
    evt_ready = 1'b0;
    do_write(1, 1, 1, 1);
    while (cyc < 55) begin
      ovr_clr = (cyc + 1 == 32 || cyc + 1 == 50) ? NCH'(2) : '0;
      step();
      ovr_clr = '0;
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL ovr_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      exp_o = (cyc >= 30 && cyc < 32) || cyc >= 40;
      checks++;
      if (overrun[1] !== exp_o) begin
        errors++; $display("FAIL ovr_bit n=%0d got %b want %b", cyc, overrun[1], exp_o);
      end
      if (cyc >= 11) begin
        checks++;
        if ({evt_valid, evt_ch} !== 3'b101) begin
          errors++; $display("FAIL ovr_hold n=%0d got %b want 101", cyc, {evt_valid, evt_ch});
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [VW-1:0] obs;
    do_reset();
    evt_ready = 1'b1;
    do_write(3, 1, 1, 2);
    while (cyc < 19) step();
    do_write(3, 1, 1, 5);
    while (cyc < 75) begin
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL coll_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
      checks++;
      if (evt_valid !== (cyc == 71)) begin
        errors++; $display("FAIL coll_evt n=%0d got %b want %b", cyc, evt_valid, cyc == 71);
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] obs;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_ch       = CHW'($urandom_range(0, NCH - 1));
      cfg_en       = ($urandom_range(0, 7) != 0);
      cfg_periodic = $urandom_range(0, 1) != 0;
      cfg_period   = CW'($urandom_range(0, 6));
      evt_ready    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) ovr_clr[i] = ($urandom_range(0, 15) == 0);
      step();
      obs = {evt_valid, evt_valid ? evt_ch : CHW'(0), active, overrun}; checks++;
      if (obs !== model_vec()) begin
        errors++; $display("FAIL random_model n=%0d got %h want %h", cyc, obs, model_vec());
      end
    end
    cfg_we = 1'b0; ovr_clr = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_arbitration();
    test_back_to_back_overrun();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
